instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction fetch stage; the producer side of the instruction-decode interface.
- Holds the program counter and issues word reads to a synchronous instruction memory with fixed 1-cycle latency.
- Buffers returned instructions in a small FIFO and delivers {instr, pc} to the decode stage over a valid/ready handshake.
- Accepts redirects from jump/branch resolution (JAL, JALR, conditional branches).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when the FIFO is empty (ADDI x0,x0,0).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- imem_req, output, 1: read request this cycle.
- imem_addr, output, 32: byte address of the request; bits [1:0] are always 0.
- imem_rdata, input, 32: instruction word, valid exactly 1 cycle after imem_req.
- redirect_valid, input, 1: load a new PC and flush.
- redirect_pc, input, 32: target PC; bits [1:0] are ignored and forced to 0.
- instr_valid, output, 1: FIFO head is valid.
- instr_ready, input, 1: decode stage accepts the head this cycle.
- instr_out, output, 32: head instruction, or NOP_INSTR when empty.
- pc_out, output, 32: PC of the head instruction, or 0 when empty.
- fetch_count, output, 32: delivered-instruction counter (see Optional Feature).

Behaviour:
- Reset values (asserted asynchronously):
  - fetch PC = RESET_PC; FIFO empty; in-flight flag = 0.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr_out = NOP_INSTR, pc_out = 0, fetch_count = 0.
- Reset mid-operation discards everything: queued entries, in-flight response and counter.
- After reset deassertion, the first imem_req is asserted in the next clock cycle with imem_addr = RESET_PC.
- Issue rule:
  - imem_req = 1 when (count + inflight) < DEPTH and redirect_valid = 0.
  - imem_addr = fetch PC.
  - On issue: fetch PC += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). The in-flight flag and tag PC are set.
- Response: in the cycle after an issue, imem_rdata is written into the FIFO tail with its PC, unless killed by a redirect.
- Handshake:
  - instr_valid = (count != 0).
  - A transfer occurs when instr_valid && instr_ready; the head pops at that clock edge.
  - instr_out and pc_out are stable while instr_valid = 1 and instr_ready = 0.
  - instr_valid never drops without a transfer, except on redirect.
- Simultaneous push and pop: both occur and count is unchanged. The full check uses the pre-edge count; the credit rule above guarantees a push never overflows.
- Latency:
  - Empty FIFO with continuous ready: instruction at imem_addr A appears on instr_out 2 cycles after its imem_req (1-cycle memory + 1-cycle FIFO write).
  - Steady-state throughput is 1 instruction per clock.
- Redirect (redirect_valid = 1 at an edge):
  - FIFO flushed; count = 0.
  - A response arriving in the following cycle is dropped (kill flag).
  - fetch PC = {redirect_pc[31:2], 2'b00}.
  - imem_req = 0 during the redirect cycle; the request to the target issues in the next cycle.
- Redirect priority:
  - Redirect has priority over push and issue.
  - A same-cycle pop still counts as a transfer, so the decoder owns that instruction.
  - Back-to-back redirects: the last one wins.
- No protocol errors are flagged. instr_ready while empty is a no-op.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - fetch_count increments by 1 on every instr_valid && instr_ready transfer and wraps at 2^32.
  - It resets to 0 and is not cleared by redirect.
- Undefined: fetch_count is constant 0 and no counter flops are synthesized.

Test Plan:
- Reset with RESET_PC = 32'h100, instr_ready = 1, memory returning addr^32'hA5A5_0000:
  - First imem_req at addr 0x100.
  - instr_out = 32'hA5A5_0100 with pc_out = 0x100 two cycles later.
  - Then 0x104, 0x108 on consecutive cycles.
- Hold instr_ready = 0 from reset:
  - Exactly DEPTH = 4 requests issue (0x0 to 0xC), then imem_req stays 0.
  - instr_out stays at the PC 0x0 word.
  - Release ready: 4 transfers on 4 consecutive cycles, in order, with fetching resuming.
- FIFO holds 3 entries and one fetch is in flight; redirect_valid = 1 with redirect_pc = 32'h2003:
  - instr_valid = 0 next cycle; the in-flight word never appears.
  - Next imem_addr = 0x2000.
  - First delivered pc_out = 0x2000.
- Redirect asserted in the same cycle as a transfer of pc 0x40:
  - The 0x40 transfer completes and counts.
  - No entry with pc 0x44 or later appears.
  - Fetch restarts at the target.
- Redirect to 32'hFFFF_FFF8 with ready = 1: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- With FETCH_PERF_EN: after 10 transfers, fetch_count = 10; after a redirect it is still 10; after asserting reset it is 0. Without the macro, fetch_count = 0 throughout.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC generation, 1-cycle imem requests and a small
// {instr, pc} FIFO toward decode. Define FETCH_PERF_EN to add the delivered-instruction counter.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] fetch_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;
  logic            started_q, started_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     instr_mem_d [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     pc_mem_d    [DEPTH];
  logic            issue, push, pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign instr_valid         = (count_q != '0);

  always_comb begin
    // Credit check counts the in-flight word so a returning response always has a free slot.
    issue      = started_q && !redirect_valid &&
                 ((32'(count_q) + 32'(inflight_q)) < DEPTH);
    push       = inflight_q && !redirect_valid;
    pop        = instr_valid && instr_ready;
    pc_d        = pc_q;
    tag_pc_d    = issue ? pc_q : tag_pc_q;
    inflight_d  = issue;
    started_d   = 1'b1;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = tag_pc_q;
        wr_ptr_d              = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      tag_pc_q    <= tag_pc_d;
      inflight_q  <= inflight_d;
      started_q   <= started_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign instr_out = instr_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign pc_out    = instr_valid ? pc_mem_q[rd_ptr_q] : 32'd0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Counts transfers even in a redirect cycle: decode owns that instruction.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pop) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fetch_count_q <= '0;
    else        fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;
`ifdef FETCH_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_queue #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: 1-cycle latency, word = addr ^ A5A5_0000.
  logic        mem_req_s = 1'b0;
  logic [31:0] mem_addr_s = '0;
  always @(negedge clock) begin
    mem_req_s  = imem_req;
    mem_addr_s = imem_addr;
  end
  always @(posedge clock) begin
    #1;
    imem_rdata = mem_req_s ? (mem_addr_s ^ XMASK) : 32'hDEAD_BEEF;
  end

  // Reference model.
  bit          m_started;
  bit          m_inflight;
  logic [31:0] m_pc, m_tag, m_fc;
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  logic        exp_req;
  bit          xfer;

  function automatic void model_reset();
    m_started  = 0;
    m_inflight = 0;
    m_pc       = RST_PC;
    m_tag      = '0;
    m_fc       = '0;
    mq_instr.delete();
    mq_pc.delete();
  endfunction

  initial model_reset();

  always @(negedge clock) begin
    if (!reset) model_reset();
    exp_req = (m_started && !redirect_valid &&
               (mq_pc.size() + int'(m_inflight) < DEPTH)) ? 1'b1 : 1'b0;
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", instr_valid, (mq_pc.size() != 0) ? 1 : 0);
    check("instr_out", instr_out, (mq_pc.size() != 0) ? mq_instr[0] : NOP);
    check("pc_out", pc_out, (mq_pc.size() != 0) ? mq_pc[0] : 32'd0);
    check("fetch_count", fetch_count, m_fc);
    if (reset) begin
      xfer = (mq_pc.size() != 0) && instr_ready;
`ifdef FETCH_PERF_EN
      if (xfer) m_fc = m_fc + 32'd1;
`endif
      if (redirect_valid) begin
        mq_instr.delete();
        mq_pc.delete();
        m_inflight = 0;
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (xfer) begin
          void'(mq_instr.pop_front());
          void'(mq_pc.pop_front());
        end
        if (m_inflight) begin
          mq_instr.push_back(m_tag ^ XMASK);
          mq_pc.push_back(m_tag);
        end
        if (exp_req) begin
          m_tag = m_pc;
          m_pc  = m_pc + 32'd4;
        end
        m_inflight = exp_req;
      end
      m_started = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    if (chk) begin
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr_out, NOP);
      check("rst_pc", pc_out, 0);
      check("rst_fc", fetch_count, 0);
    end
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int waits, g, nreq, bad, got;
    bit saw;
    logic [31:0] addrs[$];
    logic [31:0] first_pc, first_instr, fc_before;
    logic [31:0] pcs[4];
    logic [31:0] wrap_exp[4];

    // Startup latency and streaming.
    instr_ready = 1'b1;
    cyc(1);
    do_reset(1'b1);
    waits = 0;
    while (!imem_req && waits < 10) begin cyc(1); waits++; end
    check("first_req_delay", waits, 1);
    check("first_req_addr", imem_addr, 32'h100);
    cyc(2);
    check("t1_valid", instr_valid, 1);
    check("t1_instr0", instr_out, 32'hA5A5_0100);
    check("t1_pc0", pc_out, 32'h100);
    cyc(1);
    check("t1_instr1", instr_out, 32'hA5A5_0104);
    check("t1_pc1", pc_out, 32'h104);
    cyc(1);
    check("t1_instr2", instr_out, 32'hA5A5_0108);
    check("t1_pc2", pc_out, 32'h108);

    // Back-pressure: exactly DEPTH requests, then drain in order.
    instr_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (imem_req) addrs.push_back(imem_addr);
      cyc(1);
    end
    check("bp_nreq", addrs.size(), DEPTH);
    for (int i = 0; i < addrs.size() && i < DEPTH; i++)
      check("bp_addr", addrs[i], RST_PC + 32'(4 * i));
    check("bp_req_idle", imem_req, 0);
    check("bp_head", instr_out, 32'hA5A5_0100);
    instr_ready = 1'b1;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      check("drain_valid", instr_valid, 1);
      check("drain_pc", pc_out, RST_PC + 32'(4 * i));
      if (imem_req) saw = 1;
      cyc(1);
    end
    check("drain_refetch", saw, 1);

    // Redirect with 3 queued + 1 in flight.
    instr_ready = 1'b0;
    do_reset(1'b0);
    nreq = 0; g = 0;
    while (nreq < 4 && g < 20) begin
      if (imem_req) nreq++;
      cyc(1); g++;
    end
    check("rd_setup_valid", instr_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    check("rd_req_blocked", imem_req, 0);
    cyc(1);
    redirect_valid = 1'b0;
    #1;
    check("rd_flushed", instr_valid, 0);
    check("rd_addr", imem_addr, 32'h2000);
    check("rd_req", imem_req, 1);
    instr_ready = 1'b1;
    got = 0; bad = 0; first_pc = '0; first_instr = '0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid && got == 0) begin first_pc = pc_out; first_instr = instr_out; got = 1; end
      if (instr_valid && pc_out == 32'h10C) bad++;
      cyc(1);
    end
    check("rd_first_pc", first_pc, 32'h2000);
    check("rd_first_instr", first_instr, 32'hA5A5_2000);
    check("rd_no_stale", bad, 0);

    // Redirect in the same cycle as a transfer of pc 0x40.
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc(1);
    redirect_valid = 1'b0;
    g = 0;
    while (!(instr_valid && pc_out == 32'h40) && g < 20) begin cyc(1); g++; end
    check("xr_head40", pc_out, 32'h40);
    fc_before = fetch_count;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    cyc(1);
    redirect_valid = 1'b0;
    #1;
    check("xr_counted", fetch_count, fc_before + 32'(PERF));
    check("xr_flushed", instr_valid, 0);
    got = 0; bad = 0; first_pc = '0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid && got == 0) begin first_pc = pc_out; got = 1; end
      if (instr_valid && pc_out >= 32'h44 && pc_out < 32'h300) bad++;
      cyc(1);
    end
    check("xr_first_pc", first_pc, 32'h300);
    check("xr_no_stale", bad, 0);

    // PC wrap at 2^32.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc(1);
    redirect_valid = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;
    got = 0; g = 0;
    while (got < 4 && g < 20) begin
      if (instr_valid) begin pcs[got] = pc_out; got++; end
      cyc(1); g++;
    end
    check("wrap_count", got, 4);
    for (int i = 0; i < got; i++) check("wrap_pc", pcs[i], wrap_exp[i]);

    // Delivered-instruction counter.
    instr_ready = 1'b1;
    do_reset(1'b0);
    got = 0; g = 0;
    while (got < 10 && g < 100) begin
      if (instr_valid) got++;
      cyc(1); g++;
    end
    instr_ready = 1'b0;
    #1;
    check("perf_10", fetch_count, 32'(10 * PERF));
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    check("perf_after_redirect", fetch_count, 32'(10 * PERF));
    reset = 1'b0;
    #1;
    check("perf_after_reset", fetch_count, 0);
    check("reset_async_valid", instr_valid, 0);
    cyc(2);
    reset = 1'b1;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
